// File: rtl/ltl_nfa_engine_pkg.sv
// rtl/ltl_nfa_engine_pkg.sv - shared types, widths and helpers for the NFA monitor engine
//
// Purpose : start-type / config-select enums, the per-STE config record and the
//           config-data width helper used by the engine, its STEs and its bus interface.
// Ports   : none (package).
package ltl_nfa_pkg;

    // Interval bounds are held at this width; narrower symbol widths are
    // zero-extended into it, so SYMBOL_W may be anything up to this value.
    localparam int STE_SYMBOL_W = 16;

    typedef enum logic [1:0] {
        NONE          = 2'd0,
        START_OF_DATA = 2'd1,
        ALL_INPUT     = 2'd2
    } start_type_e;

    typedef enum logic [1:0] {
        CFG_INTERVAL = 2'd0,
        CFG_EDGES    = 2'd1,
        CFG_ATTR     = 2'd2
    } cfg_sel_e;

    typedef struct packed {
        logic [STE_SYMBOL_W-1:0] lo;
        logic [STE_SYMBOL_W-1:0] hi;
        start_type_e             start_type;
        logic                    report;
    } ste_cfg_t;

    // Config data must carry an interval pair, a full edge mask or the attribute bits.
    function automatic int cfg_width(input int sym_w, input int num_ste);
        int w;
        w = 2 * sym_w;
        if (num_ste > w) w = num_ste;
        if (w < 3) w = 3;
        return w;
    endfunction

endpackage

// File: rtl/ltl_nfa_engine_if.sv
// rtl/ltl_nfa_engine_if.sv - symbol stream and config bus between encoder/host and the NFA engine
//
// Purpose : bundles the symbol advance (run, symbols) and the config write bus
//           (cfg_we, cfg_sel, cfg_addr, cfg_data, cfg_err).
// Modports: master drives run/symbols/cfg_*, samples cfg_err; slave is the engine side.
interface ltl_nfa_engine_if #(
    parameter int NUM_STE  = 16,
    parameter int SYMBOL_W = 8
) ();
    import ltl_nfa_pkg::*;

    localparam int CFG_W  = cfg_width(SYMBOL_W, NUM_STE);
    localparam int ADDR_W = $clog2(NUM_STE);

    logic                run;
    logic [SYMBOL_W-1:0] symbols;
    logic                cfg_we;
    logic [1:0]          cfg_sel;
    logic [ADDR_W-1:0]   cfg_addr;
    logic [CFG_W-1:0]    cfg_data;
    logic                cfg_err;

    modport master (
        output run, symbols, cfg_we, cfg_sel, cfg_addr, cfg_data,
        input  cfg_err
    );

    modport slave (
        input  run, symbols, cfg_we, cfg_sel, cfg_addr, cfg_data,
        output cfg_err
    );

endinterface

// File: rtl/ltl_nfa_engine_ste.sv
// rtl/ltl_nfa_engine_ste.sv - one state-transition element: config registers and interval match
//
// Purpose : holds one STE's interval, incoming-edge mask, start type and report flag;
//           produces match (symbol in [lo,hi]) and en (start condition or active predecessor).
// Ports   : clk, reset; cfg_we (already decoded for this STE and qualified), cfg_sel,
//           cfg_data; symbols, active_vec, sod_pending in; match, en, report out.
module ltl_nfa_ste
    import ltl_nfa_pkg::*;
#(
    parameter int NUM_STE  = 16,
    parameter int SYMBOL_W = 8,
    parameter int CFG_W    = 16
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                cfg_we,
    input  logic [1:0]          cfg_sel,
    input  logic [CFG_W-1:0]    cfg_data,
    input  logic [SYMBOL_W-1:0] symbols,
    input  logic [NUM_STE-1:0]  active_vec,
    input  logic                sod_pending,
    output logic                match,
    output logic                en,
    output logic                report
);

    ste_cfg_t             cfg_q, cfg_d;
    logic [NUM_STE-1:0]   edge_q, edge_d;
    logic [STE_SYMBOL_W-1:0] sym_ext;

    always_comb begin
        cfg_d  = cfg_q;
        edge_d = edge_q;
        if (cfg_we) begin
            case (cfg_sel_e'(cfg_sel))
                CFG_INTERVAL: begin
                    cfg_d.lo = STE_SYMBOL_W'(cfg_data[SYMBOL_W-1:0]);
                    cfg_d.hi = STE_SYMBOL_W'(cfg_data[2*SYMBOL_W-1:SYMBOL_W]);
                end
                CFG_EDGES: edge_d = cfg_data[NUM_STE-1:0];
                CFG_ATTR: begin
                    // Code 3 is stored as-is and behaves like NONE below.
                    cfg_d.start_type = start_type_e'(cfg_data[1:0]);
                    cfg_d.report     = cfg_data[2];
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            // lo above hi: the STE can never match until programmed.
            cfg_q.lo         <= '1;
            cfg_q.hi         <= '0;
            cfg_q.start_type <= NONE;
            cfg_q.report     <= 1'b0;
            edge_q           <= '0;
        end else begin
            cfg_q  <= cfg_d;
            edge_q <= edge_d;
        end
    end

    assign sym_ext = STE_SYMBOL_W'(symbols);
    assign match   = (sym_ext >= cfg_q.lo) && (sym_ext <= cfg_q.hi);
    assign en      = ((cfg_q.start_type == START_OF_DATA) && sod_pending) ||
                     (cfg_q.start_type == ALL_INPUT) ||
                     (|(active_vec & edge_q));
    assign report  = cfg_q.report;

endmodule

// File: rtl/ltl_nfa_engine.sv
// rtl/ltl_nfa_engine.sv - runtime-programmable homogeneous NFA monitor engine
//
// Purpose : NUM_STE STEs advanced once per run cycle; sticky reports, saturating symbol
//           count and first-report position capture.
// Ports   : clk, reset (sync, active-high); bus (slave: run, symbols, cfg_* in, cfg_err out);
//           active_state, report_vec, report_any, report_sticky, sym_count,
//           first_report_valid, first_report_pos out.
module ltl_nfa_engine
    import ltl_nfa_pkg::*;
#(
    parameter int NUM_STE  = 16,
    parameter int SYMBOL_W = 8,
    parameter int CNT_W    = 32
) (
    input  logic               clk,
    input  logic               reset,
    ltl_nfa_engine_if.slave    bus,
    output logic [NUM_STE-1:0] active_state,
    output logic [NUM_STE-1:0] report_vec,
    output logic               report_any,
    output logic [NUM_STE-1:0] report_sticky,
    output logic [CNT_W-1:0]   sym_count,
    output logic               first_report_valid,
    output logic [CNT_W-1:0]   first_report_pos
);

    localparam int CFG_W  = cfg_width(SYMBOL_W, NUM_STE);
    localparam int ADDR_W = $clog2(NUM_STE);

    logic [NUM_STE-1:0] active_q, active_d;
    logic [NUM_STE-1:0] sticky_q, sticky_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [CNT_W-1:0]   frp_q, frp_d;
    logic               frv_q, frv_d;
    logic               sod_q, sod_d;
    logic               err_q, err_d;

    logic [NUM_STE-1:0] match_vec, en_vec, report_mask;
    logic               cfg_bad, cfg_ok;

    // Writes are only legal while the engine is paused, to a real STE and field.
    assign cfg_bad = bus.run || (bus.cfg_sel == 2'd3) ||
                     (32'(bus.cfg_addr) >= 32'(NUM_STE));
    assign cfg_ok  = bus.cfg_we && !cfg_bad;

    for (genvar i = 0; i < NUM_STE; i++) begin : g_ste
        ltl_nfa_ste #(
            .NUM_STE  (NUM_STE),
            .SYMBOL_W (SYMBOL_W),
            .CFG_W    (CFG_W)
        ) u_ste (
            .clk         (clk),
            .reset       (reset),
            .cfg_we      (cfg_ok && (bus.cfg_addr == ADDR_W'(i))),
            .cfg_sel     (bus.cfg_sel),
            .cfg_data    (bus.cfg_data),
            .symbols     (bus.symbols),
            .active_vec  (active_q),
            .sod_pending (sod_q),
            .match       (match_vec[i]),
            .en          (en_vec[i]),
            .report      (report_mask[i])
        );
    end

    assign report_vec = active_q & report_mask;
    assign report_any = |report_vec;

    always_comb begin
        active_d = active_q;
        sod_d    = sod_q;
        cnt_d    = cnt_q;
        sticky_d = sticky_q | report_vec;
        frv_d    = frv_q;
        frp_d    = frp_q;
        err_d    = bus.cfg_we && cfg_bad;
        if (bus.run) begin
            active_d = en_vec & match_vec;
            sod_d    = 1'b0;
            if (cnt_q != '1) cnt_d = cnt_q + CNT_W'(1);
        end
        // The causing symbol was counted on the previous edge, hence the -1.
        if (report_any && !frv_q) begin
            frv_d = 1'b1;
            frp_d = cnt_q - CNT_W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            active_q <= '0;
            sticky_q <= '0;
            cnt_q    <= '0;
            frv_q    <= 1'b0;
            frp_q    <= '0;
            sod_q    <= 1'b1;
            err_q    <= 1'b0;
        end else begin
            active_q <= active_d;
            sticky_q <= sticky_d;
            cnt_q    <= cnt_d;
            frv_q    <= frv_d;
            frp_q    <= frp_d;
            sod_q    <= sod_d;
            err_q    <= err_d;
        end
    end

    assign active_state       = active_q;
    assign report_sticky      = sticky_q;
    assign sym_count          = cnt_q;
    assign first_report_valid = frv_q;
    assign first_report_pos   = frp_q;
    assign bus.cfg_err        = err_q;

endmodule

// File: tb/tb_ltl_nfa_engine.sv
// tb/tb_ltl_nfa_engine.sv - self-checking bench for ltl_nfa_engine with a reference NFA model
module tb_ltl_nfa_engine;

    localparam int N  = 11;
    localparam int SW = 8;
    localparam int CW = 4;

    logic clk = 1'b0;
    logic reset = 1'b1;
    always #5 clk = ~clk;

    ltl_nfa_engine_if #(.NUM_STE(N), .SYMBOL_W(SW)) bus ();

    logic [N-1:0]  active_state, report_vec, report_sticky;
    logic          report_any, first_report_valid;
    logic [CW-1:0] sym_count, first_report_pos;

    ltl_nfa_engine #(.NUM_STE(N), .SYMBOL_W(SW), .CNT_W(CW)) dut (
        .clk                (clk),
        .reset              (reset),
        .bus                (bus),
        .active_state       (active_state),
        .report_vec         (report_vec),
        .report_any         (report_any),
        .report_sticky      (report_sticky),
        .sym_count          (sym_count),
        .first_report_valid (first_report_valid),
        .first_report_pos   (first_report_pos)
    );

    typedef struct {
        logic [N-1:0]  act;
        logic [N-1:0]  rv;
        logic          rany;
        logic [N-1:0]  sticky;
        logic [CW-1:0] cnt;
        logic          frv;
        logic [CW-1:0] frp;
        logic          err;
    } exp_t;

    exp_t exp_q[$];

    int n_checks = 0;
    int n_fail   = 0;

    // Reference model state
    logic [7:0]    m_lo[N];
    logic [7:0]    m_hi[N];
    logic [N-1:0]  m_edge[N];
    logic [1:0]    m_st[N];
    logic [N-1:0]  m_rep;
    logic [N-1:0]  m_act, m_sticky;
    logic          m_sod, m_frv, m_err;
    logic [CW-1:0] m_cnt, m_frp;

    task automatic check_eq(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s act=%0h exp=%0h", tag, act, exp);
        end
    endtask

    task automatic model(input logic rst, input logic r, input logic [7:0] sym,
                         input logic we, input logic [1:0] sel, input logic [3:0] addr,
                         input logic [15:0] data);
        logic [N-1:0] rv, nact;
        logic bad, e;
        if (rst) begin
            for (int i = 0; i < N; i++) begin
                m_lo[i] = 8'hFF; m_hi[i] = 8'h00; m_edge[i] = '0; m_st[i] = 2'd0;
            end
            m_rep = '0; m_act = '0; m_sticky = '0; m_sod = 1'b1;
            m_frv = 1'b0; m_err = 1'b0; m_cnt = '0; m_frp = '0;
            return;
        end
        rv  = m_act & m_rep;
        bad = we && (r || sel == 2'd3 || addr >= 4'(N));
        for (int i = 0; i < N; i++) begin
            e = (m_st[i] == 2'd1 && m_sod) || (m_st[i] == 2'd2) || (|(m_act & m_edge[i]));
            nact[i] = e && (sym >= m_lo[i]) && (sym <= m_hi[i]);
        end
        m_sticky = m_sticky | rv;
        if ((|rv) && !m_frv) begin
            m_frv = 1'b1;
            m_frp = m_cnt - 4'd1;
        end
        if (r) begin
            m_act = nact;
            m_sod = 1'b0;
            if (m_cnt != 4'hF) m_cnt = m_cnt + 4'd1;
        end
        if (we && !bad) begin
            case (sel)
                2'd0: begin m_lo[addr] = data[7:0]; m_hi[addr] = data[15:8]; end
                2'd1: m_edge[addr] = data[N-1:0];
                default: begin m_st[addr] = data[1:0]; m_rep[addr] = data[2]; end
            endcase
        end
        m_err = bad;
    endtask

    task automatic step(input logic rst, input logic r, input logic [7:0] sym,
                        input logic we, input logic [1:0] sel, input logic [3:0] addr,
                        input logic [15:0] data);
        exp_t e, got;
        @(negedge clk);
        reset        = rst;
        bus.run      = r;
        bus.symbols  = sym;
        bus.cfg_we   = we;
        bus.cfg_sel  = sel;
        bus.cfg_addr = addr;
        bus.cfg_data = data;
        model(rst, r, sym, we, sel, addr, data);
        e.act = m_act; e.rv = m_act & m_rep; e.rany = |(m_act & m_rep);
        e.sticky = m_sticky; e.cnt = m_cnt; e.frv = m_frv; e.frp = m_frp; e.err = m_err;
        exp_q.push_back(e);
        @(posedge clk);
        #1;
        got = exp_q.pop_front();
        check_eq("active_state", 32'(active_state), 32'(got.act));
        check_eq("report_vec", 32'(report_vec), 32'(got.rv));
        check_eq("report_any", 32'(report_any), 32'(got.rany));
        check_eq("report_sticky", 32'(report_sticky), 32'(got.sticky));
        check_eq("sym_count", 32'(sym_count), 32'(got.cnt));
        check_eq("first_report_valid", 32'(first_report_valid), 32'(got.frv));
        check_eq("first_report_pos", 32'(first_report_pos), 32'(got.frp));
        check_eq("cfg_err", 32'(bus.cfg_err), 32'(got.err));
    endtask

    task automatic do_reset();
        step(1'b1, 1'b0, 8'h00, 1'b0, 2'd0, 4'd0, 16'h0000);
    endtask

    task automatic cfg(input logic [1:0] sel, input logic [3:0] addr, input logic [15:0] data);
        step(1'b0, 1'b0, 8'h00, 1'b1, sel, addr, data);
    endtask

    task automatic feed(input logic [7:0] sym);
        step(1'b0, 1'b1, sym, 1'b0, 2'd0, 4'd0, 16'h0000);
    endtask

    task automatic idle();
        step(1'b0, 1'b0, 8'h00, 1'b0, 2'd0, 4'd0, 16'h0000);
    endtask

    task automatic program_quadrant();
        cfg(2'd0, 4'd0, 16'h3F00);   // STE0 [0,63]
        cfg(2'd1, 4'd0, 16'h0001);   // self-loop
        cfg(2'd2, 4'd0, 16'h0001);   // START_OF_DATA
        cfg(2'd0, 4'd1, 16'h7F40);   // STE1 [64,127] after STE0
        cfg(2'd1, 4'd1, 16'h0001);
        cfg(2'd0, 4'd3, 16'hFFC0);   // STE3 [192,255]
        cfg(2'd2, 4'd3, 16'h0005);   // START_OF_DATA + report
    endtask

    initial begin
        bus.run = 1'b0; bus.symbols = '0; bus.cfg_we = 1'b0;
        bus.cfg_sel = '0; bus.cfg_addr = '0; bus.cfg_data = '0;

        // Reset state and unprogrammed run
        do_reset();
        feed(8'h00); feed(8'h40); feed(8'h80); feed(8'hC0); feed(8'hFF);
        idle();

        // Quadrant: immediate high-quadrant report
        do_reset();
        program_quadrant();
        feed(8'hC8);
        idle();
        idle();

        // Quadrant: start-of-data consumed by first symbol
        do_reset();
        program_quadrant();
        feed(8'h10); feed(8'h10); feed(8'hC8);
        idle();

        // Chain STE0 -> STE1
        do_reset();
        cfg(2'd0, 4'd0, 16'h3F00);
        cfg(2'd2, 4'd0, 16'h0001);
        cfg(2'd0, 4'd1, 16'hFF40);
        cfg(2'd1, 4'd1, 16'h0001);
        cfg(2'd2, 4'd1, 16'h0004);
        feed(8'h05); feed(8'h40);
        idle();
        feed(8'h05);
        idle();

        // Rejected writes leave config untouched
        do_reset();
        cfg(2'd0, 4'd2, 16'hAAAA);
        cfg(2'd2, 4'd2, 16'h0006);   // ALL_INPUT + report
        step(1'b0, 1'b1, 8'hAA, 1'b1, 2'd0, 4'd2, 16'h0000);
        feed(8'hAA);
        cfg(2'd0, 4'(N), 16'h0000);
        cfg(2'd3, 4'd2, 16'h0000);
        idle();
        feed(8'hAA);

        // Saturation, late report, then reset with a colliding write
        for (int k = 0; k < 20; k++) feed((k == 17) ? 8'hAA : 8'h00);
        idle();
        step(1'b1, 1'b1, 8'hAA, 1'b1, 2'd2, 4'd2, 16'h0006);
        feed(8'hAA);
        idle();

        // Random symbols against the quadrant monitor
        do_reset();
        program_quadrant();
        for (int k = 0; k < 30; k++) begin
            case ($urandom_range(0, 3))
                0: feed(8'h10);
                1: feed(8'h50);
                2: feed(8'h90);
                default: feed(8'hC8);
            endcase
        end

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
